// File: rtl/alu_input_seq_if.sv
// Switch/button inputs and operand/status outputs of the ALU operand sequencer.
// The bench or board drives through master; the sequencer owns slave.
interface alu_input_seq_if #(
  parameter int N    = 4,
  parameter int NSel = 6
);
  logic [15:0]     i_sw;
  logic            i_button_next;
  logic            i_button_clear;
  logic [N-1:0]    o_alu_A;
  logic [N-1:0]    o_alu_B;
  logic [NSel-1:0] o_alu_Op;
  logic [1:0]      o_state;
  logic            o_valid;
  logic            o_show;

  modport master (
    output i_sw, i_button_next, i_button_clear,
    input  o_alu_A, o_alu_B, o_alu_Op, o_state, o_valid, o_show
  );
  modport slave (
    input  i_sw, i_button_next, i_button_clear,
    output o_alu_A, o_alu_B, o_alu_Op, o_state, o_valid, o_show
  );
endinterface

// File: rtl/alu_input_seq.sv
// Operand sequencer: debounced "next" steps LOAD_A -> LOAD_B -> LOAD_OP -> SHOW,
// "clear" returns to LOAD_A without touching the latched operands.

// One button lane: 2-FF synchroniser, counter debounce, rising-edge press event.
module alu_input_seq_btn #(
  parameter int DB_CYCLES = 100000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  // db flips on the DB_CYCLES-th consecutive disagreeing sample, so cnt tops out
  // at DB_CYCLES-1 and never wraps.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      db_q <= db;
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = db & ~db_q;
endmodule

module alu_input_seq #(
  parameter int N         = 4,
  parameter int NSel      = 6,
  parameter int DB_CYCLES = 100000
) (
  input logic       i_clock,
  input logic       i_reset_n,
  alu_input_seq_if.slave bus
);
  localparam int NUM_BTN = 2;
  localparam int BTN_NXT = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;

  assign raw[BTN_NXT] = bus.i_button_next;
  assign raw[BTN_CLR] = bus.i_button_clear;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    alu_input_seq_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .raw      (raw[i]),
      .press    (press[i])
    );
  end

  logic clr_ev;
  logic nxt_ev;
  assign clr_ev = press[BTN_CLR];
  assign nxt_ev = press[BTN_NXT] & ~press[BTN_CLR];

  state_t          state;
  state_t          state_nxt;
  logic            ld_a;
  logic            ld_b;
  logic            ld_op;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [NSel-1:0] alu_op;
  logic            valid;
  logic            show;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= LOAD_A;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_ev) begin
      state_nxt = LOAD_A;
    end else if (nxt_ev) begin
      case (state)
        LOAD_A:  state_nxt = LOAD_B;
        LOAD_B:  state_nxt = LOAD_OP;
        LOAD_OP: state_nxt = SHOW;
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  always_comb begin
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    ld_op = 1'b0;
    if (nxt_ev) begin
      case (state)
        LOAD_A:  ld_a  = 1'b1;
        LOAD_B:  ld_b  = 1'b1;
        LOAD_OP: ld_op = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand registers and status flags; all outputs come straight from flops.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      valid  <= 1'b0;
      show   <= 1'b0;
    end else begin
      if (ld_a)  alu_a  <= bus.i_sw[N-1:0];
      if (ld_b)  alu_b  <= bus.i_sw[N-1:0];
      if (ld_op) alu_op <= bus.i_sw[NSel-1:0];
      valid <= ld_op;
      show  <= (state_nxt == SHOW);
    end
  end

  assign bus.o_alu_A  = alu_a;
  assign bus.o_alu_B  = alu_b;
  assign bus.o_alu_Op = alu_op;
  assign bus.o_state  = state;
  assign bus.o_valid  = valid;
  assign bus.o_show   = show;
endmodule
